wb_writeback_unit: RTL and testbench

//  Final pipeline stage: accepts retiring results from MEM, waits for variable-latency SRAM load data,
//  and drives the register-file write port (WB_Dest/WB_Value/WB_WB_EN) as a registered one-cycle pulse.

---
 rtl/wb_writeback_unit_pkg.sv | 20 ++
 rtl/wb_writeback_unit_if.sv | 40 ++++
 rtl/wb_writeback_unit_timeout_ctr.sv | 30 +++
 rtl/wb_writeback_unit.sv | 118 +++++++++++
 tb/tb_wb_writeback_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_writeback_unit_pkg.sv
// Shared definitions for the writeback stage: state encoding, the PC register index and the
// default load timeout. The hazard unit imports the same package.
package wb_writeback_unit_pkg;

   typedef enum logic {
      WB_IDLE     = 1'b0,
      WB_WAIT_MEM = 1'b1
   } wb_state_e;

   localparam int          WB_DATA_W_DFLT  = 32;
   localparam int          WB_REG_AW_DFLT  = 4;
   localparam int          WB_TIMEOUT_DFLT = 16;
   localparam logic [3:0]  REG_PC          = 4'hF;

   // Timer width that can hold TIMEOUT-1.
   function automatic int timer_w(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/wb_writeback_unit_if.sv
// MEM handshake, SRAM load return and register-file write port of the writeback stage.
// The retire_cnt signal exists only when WB_RETIRE_CNT_EN is defined.
interface wb_writeback_unit_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              mem_valid;
   logic              mem_ready;
   logic              MEM_WB_EN;
   logic              MEM_R_EN;
   logic [REG_AW-1:0] MEM_Dest;
   logic [DATA_W-1:0] ALU_Res;
   logic              sram_rvalid;
   logic [DATA_W-1:0] sram_rdata;
   logic [REG_AW-1:0] WB_Dest;
   logic [DATA_W-1:0] WB_Value;
   logic              WB_WB_EN;
   logic              wb_err;
`ifdef WB_RETIRE_CNT_EN
   logic [31:0]       retire_cnt;

   modport slave (
      input  mem_valid, MEM_WB_EN, MEM_R_EN, MEM_Dest, ALU_Res, sram_rvalid, sram_rdata,
      output mem_ready, WB_Dest, WB_Value, WB_WB_EN, wb_err, retire_cnt
   );
   modport master (
      output mem_valid, MEM_WB_EN, MEM_R_EN, MEM_Dest, ALU_Res, sram_rvalid, sram_rdata,
      input  mem_ready, WB_Dest, WB_Value, WB_WB_EN, wb_err, retire_cnt
   );
`else
   modport slave (
      input  mem_valid, MEM_WB_EN, MEM_R_EN, MEM_Dest, ALU_Res, sram_rvalid, sram_rdata,
      output mem_ready, WB_Dest, WB_Value, WB_WB_EN, wb_err
   );
   modport master (
      output mem_valid, MEM_WB_EN, MEM_R_EN, MEM_Dest, ALU_Res, sram_rvalid, sram_rdata,
      input  mem_ready, WB_Dest, WB_Value, WB_WB_EN, wb_err
   );
`endif
endinterface

// File: rtl/wb_writeback_unit_timeout_ctr.sv
// Load-wait timer: cleared on load accept, counts while enabled, flags expiry at TIMEOUT-1.
module wb_timeout_ctr
   import wb_writeback_unit_pkg::*;
#(
   parameter int TIMEOUT = WB_TIMEOUT_DFLT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int CW = timer_w(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

   // Holds at the terminal count so a stale timer never wraps back into range.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                cnt_d = '0;
      else if (en_i && !expire_o) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/wb_writeback_unit.sv
// Writeback stage: retires MEM results, waits for SRAM load data, drives a registered
// register-file write pulse. Optional retire counter under WB_RETIRE_CNT_EN.
module wb_writeback_unit
   import wb_writeback_unit_pkg::*;
#(
   parameter int DATA_W  = WB_DATA_W_DFLT,
   parameter int REG_AW  = WB_REG_AW_DFLT,
   parameter int TIMEOUT = WB_TIMEOUT_DFLT
) (
   input logic               clk,
   input logic               rst,
   wb_writeback_unit_if.slave bus
);
   localparam logic [REG_AW-1:0] PC_IDX = '1;

   wb_state_e         state_q, state_d;
   logic [REG_AW-1:0] dest_q, dest_d;
   logic [DATA_W-1:0] value_q, value_d;
   logic              wben_q, wben_d;
   logic              err_q, err_d;
   logic [REG_AW-1:0] ld_dest_q, ld_dest_d;
   logic              ld_wben_q, ld_wben_d;
   logic              mem_ready;
   logic              tmr_clr, tmr_en, tmr_exp;

   wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expire_o (tmr_exp)
   );

   always_comb begin
      state_d   = state_q;
      dest_d    = dest_q;
      value_d   = value_q;
      wben_d    = 1'b0;
      err_d     = err_q;
      ld_dest_d = ld_dest_q;
      ld_wben_d = ld_wben_q;
      tmr_clr   = 1'b0;
      tmr_en    = 1'b0;
      mem_ready = 1'b0;
      case (state_q)
         WB_IDLE: begin
            mem_ready = 1'b1;
            // No load outstanding, so any returning data is unsolicited.
            if (bus.sram_rvalid) err_d = 1'b1;
            if (bus.mem_valid) begin
               if (bus.MEM_R_EN) begin
                  ld_dest_d = bus.MEM_Dest;
                  ld_wben_d = bus.MEM_WB_EN;
                  tmr_clr   = 1'b1;
                  state_d   = WB_WAIT_MEM;
               end else begin
                  wben_d  = bus.MEM_WB_EN && (bus.MEM_Dest != PC_IDX);
                  value_d = bus.ALU_Res;
                  dest_d  = bus.MEM_Dest;
               end
            end
         end
         WB_WAIT_MEM: begin
            tmr_en = 1'b1;
            // Data arriving on the expiry cycle still completes the load.
            if (bus.sram_rvalid) begin
               wben_d  = ld_wben_q && (ld_dest_q != PC_IDX);
               value_d = bus.sram_rdata;
               dest_d  = ld_dest_q;
               state_d = WB_IDLE;
            end else if (tmr_exp) begin
               err_d   = 1'b1;
               state_d = WB_IDLE;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= WB_IDLE;
         dest_q    <= '0;
         value_q   <= '0;
         wben_q    <= 1'b0;
         err_q     <= 1'b0;
         ld_dest_q <= '0;
         ld_wben_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dest_q    <= dest_d;
         value_q   <= value_d;
         wben_q    <= wben_d;
         err_q     <= err_d;
         ld_dest_q <= ld_dest_d;
         ld_wben_q <= ld_wben_d;
      end
   end

   assign bus.mem_ready = mem_ready;
   assign bus.WB_Dest   = dest_q;
   assign bus.WB_Value  = value_q;
   assign bus.WB_WB_EN  = wben_q;
   assign bus.wb_err    = err_q;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_q, retire_d;

   assign retire_d = wben_q ? retire_q + 32'd1 : retire_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) retire_q <= '0;
      else      retire_q <= retire_d;
   end

   assign bus.retire_cnt = retire_q;
`endif
endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed bench for wb_writeback_unit: ALU retire, loads, timeout, R15 suppression, reset.
module tb_wb_writeback_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc;
   logic seen_wb;

   always #5 clk = ~clk;

   wb_writeback_unit_if #(.DATA_W(32), .REG_AW(4)) bus ();

   wb_writeback_unit #(.DATA_W(32), .REG_AW(4), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic wben, input logic ren,
                        input logic [3:0] dest, input logic [31:0] alu);
      bus.mem_valid = v;
      bus.MEM_WB_EN = wben;
      bus.MEM_R_EN  = ren;
      bus.MEM_Dest  = dest;
      bus.ALU_Res   = alu;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      tick;
      tick;
      rst = 1'b1;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
      bus.sram_rvalid = 1'b0;
      bus.sram_rdata  = 32'h0;
      tick;
      tick;
      // Reset state
      chk("rst_wben",  {31'h0, bus.WB_WB_EN}, 32'h0);
      chk("rst_dest",  {28'h0, bus.WB_Dest},  32'h0);
      chk("rst_value", bus.WB_Value,          32'h0);
      chk("rst_err",   {31'h0, bus.wb_err},   32'h0);
      chk("rst_ready", {31'h0, bus.mem_ready}, 32'h1);
      rst = 1'b1;

      // 1: single ALU op
      drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h1234);
      tick;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      chk("alu_wben",  {31'h0, bus.WB_WB_EN}, 32'h1);
      chk("alu_dest",  {28'h0, bus.WB_Dest},  32'd3);
      chk("alu_value", bus.WB_Value,          32'h1234);
      tick;
      chk("alu_pulse_end", {31'h0, bus.WB_WB_EN}, 32'h0);
      chk("alu_hold_val",  bus.WB_Value,          32'h1234);

      // 2: back-to-back ALU ops
      drive(1'b1, 1'b1, 1'b0, 4'd1, 32'h11);
      tick;
      chk("b2b_wben1",  {31'h0, bus.WB_WB_EN},  32'h1);
      chk("b2b_dest1",  {28'h0, bus.WB_Dest},   32'd1);
      chk("b2b_ready",  {31'h0, bus.mem_ready}, 32'h1);
      drive(1'b1, 1'b1, 1'b0, 4'd2, 32'h22);
      tick;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      chk("b2b_wben2",  {31'h0, bus.WB_WB_EN}, 32'h1);
      chk("b2b_dest2",  {28'h0, bus.WB_Dest},  32'd2);
      chk("b2b_value2", bus.WB_Value,          32'h22);
      tick;

      // 3: load to R5, data sampled on the 4th edge after accept
      drive(1'b1, 1'b1, 1'b1, 4'd5, 32'h5555);
      tick;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      cyc = 0;
      seen_wb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!bus.mem_ready) cyc++;
         if (bus.WB_WB_EN) seen_wb = 1'b1;
         if (i == 3) begin
            bus.sram_rvalid = 1'b1;
            bus.sram_rdata  = 32'hDEADBEEF;
         end
         tick;
      end
      bus.sram_rvalid = 1'b0;
      chk("ld_busy_cycles", cyc,                   32'd4);
      chk("ld_no_early_wb", {31'h0, seen_wb},      32'h0);
      chk("ld_wben",        {31'h0, bus.WB_WB_EN}, 32'h1);
      chk("ld_dest",        {28'h0, bus.WB_Dest},  32'd5);
      chk("ld_value",       bus.WB_Value,          32'hDEADBEEF);
      chk("ld_ready",       {31'h0, bus.mem_ready}, 32'h1);
      chk("ld_err",         {31'h0, bus.wb_err},   32'h0);
`ifdef WB_RETIRE_CNT_EN
      tick;
      chk("retire_cnt4", bus.retire_cnt, 32'd4);
`endif

      // Minimum load latency: data the cycle after accept
      drive(1'b1, 1'b1, 1'b1, 4'd9, 32'h0);
      tick;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      bus.sram_rvalid = 1'b1;
      bus.sram_rdata  = 32'h0000_9999;
      tick;
      bus.sram_rvalid = 1'b0;
      chk("ld_min_wben",  {31'h0, bus.WB_WB_EN}, 32'h1);
      chk("ld_min_value", bus.WB_Value,          32'h0000_9999);

      // MEM_WB_EN=0 ALU op writes nothing
      drive(1'b1, 1'b0, 1'b0, 4'd4, 32'h44);
      tick;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      chk("nowb_wben", {31'h0, bus.WB_WB_EN}, 32'h0);

      // 5: R15 ALU op and R15 load are suppressed
      drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h77);
      tick;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      chk("r15_alu_wben", {31'h0, bus.WB_WB_EN}, 32'h0);
      drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h0);
      tick;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      chk("r15_ld_waits", {31'h0, bus.mem_ready}, 32'h0);
      bus.sram_rvalid = 1'b1;
      bus.sram_rdata  = 32'h99;
      tick;
      bus.sram_rvalid = 1'b0;
      chk("r15_ld_wben",  {31'h0, bus.WB_WB_EN},  32'h0);
      chk("r15_ld_ready", {31'h0, bus.mem_ready}, 32'h1);
      chk("r15_ld_err",   {31'h0, bus.wb_err},    32'h0);

      // 4: load with no response times out after 16 cycles in WAIT_MEM
      drive(1'b1, 1'b1, 1'b1, 4'd6, 32'h0);
      tick;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      cyc = 0;
      seen_wb = 1'b0;
      while (!bus.mem_ready && cyc < 40) begin
         if (bus.wb_err) seen_wb = 1'b1;
         if (bus.WB_WB_EN) seen_wb = 1'b1;
         tick;
         cyc++;
      end
      chk("to_cycles",   cyc,                  32'd16);
      chk("to_no_early", {31'h0, seen_wb},     32'h0);
      chk("to_err",      {31'h0, bus.wb_err},  32'h1);
      chk("to_wben",     {31'h0, bus.WB_WB_EN}, 32'h0);

      // 6: reset mid-WAIT_MEM
      drive(1'b1, 1'b1, 1'b1, 4'd7, 32'h0);
      tick;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      tick;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_dest",  {28'h0, bus.WB_Dest},   32'h0);
      chk("arst_value", bus.WB_Value,           32'h0);
      chk("arst_err",   {31'h0, bus.wb_err},    32'h0);
      chk("arst_ready", {31'h0, bus.mem_ready}, 32'h1);
`ifdef WB_RETIRE_CNT_EN
      chk("arst_retire", bus.retire_cnt, 32'h0);
`endif
      tick;
      rst = 1'b1;
      bus.sram_rvalid = 1'b1;
      bus.sram_rdata  = 32'hAA;
      tick;
      bus.sram_rvalid = 1'b0;
      chk("stale_rv_wben", {31'h0, bus.WB_WB_EN}, 32'h0);
      chk("idle_rv_err",   {31'h0, bus.wb_err},   32'h1);
      tick;
      chk("err_sticky",    {31'h0, bus.wb_err},   32'h1);

      // Data on the expiry cycle wins over the timeout
      do_reset;
      drive(1'b1, 1'b1, 1'b1, 4'd8, 32'h0);
      tick;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      for (int i = 0; i < 15; i++) tick;
      chk("edge_still_busy", {31'h0, bus.mem_ready}, 32'h0);
      bus.sram_rvalid = 1'b1;
      bus.sram_rdata  = 32'h8888;
      tick;
      bus.sram_rvalid = 1'b0;
      chk("edge_wben",  {31'h0, bus.WB_WB_EN}, 32'h1);
      chk("edge_dest",  {28'h0, bus.WB_Dest},  32'd8);
      chk("edge_value", bus.WB_Value,          32'h8888);
      chk("edge_err",   {31'h0, bus.wb_err},   32'h0);
      tick;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
